// File: rtl/lock_sequencer.sv
// lock_sequencer: attempt controller for the digital lock.
// Arbitrates one-cycle button pulses, assembles a CODE_LEN-digit entry,
// compares it against SECRET and sequences the OPEN / failed-attempt phases.
// Optional feature macro: LOCK_LOCKOUT_EN builds the LOCKOUT phase and its
// timer; without it a mismatch always returns to IDLE and locked_out is 0.
module lock_sequencer #(
    parameter int unsigned            CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]  SECRET         = 8'b00_01_10_11,
    parameter int unsigned            TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned            OPEN_CYCLES    = 30_000_000,
    parameter int unsigned            LOCKOUT_CYCLES = 100_000_000,
    parameter int unsigned            MAX_FAILS      = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [3:0]                        button,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic                              collision,
    output logic [2:0]                        state,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt
);

    localparam int unsigned DCW  = $clog2(CODE_LEN + 1);
    localparam int unsigned FCW  = $clog2(MAX_FAILS + 1);
    localparam int unsigned EW   = 2 * CODE_LEN;
    // One timer is shared by the entry, open and lockout phases.
    localparam int unsigned T_AB = (TIMEOUT_CYCLES > OPEN_CYCLES) ? TIMEOUT_CYCLES : OPEN_CYCLES;
    localparam int unsigned TMAX = (T_AB > LOCKOUT_CYCLES) ? T_AB : LOCKOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [DCW-1:0]  digit_cnt_q, digit_cnt_d;
    logic [FCW-1:0]  fail_cnt_q, fail_cnt_d;
    logic [EW-1:0]   entry_q, entry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            unlocked_q, unlocked_d;
    logic            collision_q, collision_d;

    logic            btn_valid;
    logic [1:0]      digit;
    logic [DCW-1:0]  cnt_inc;
    logic [FCW-1:0]  fail_inc;
    logic            timer_zero;

    // Lowest-index press wins; the saturating fail increment is shared by both builds.
    always_comb begin
        btn_valid  = |button;
        digit      = 2'd3;
        if (button[0])      digit = 2'd0;
        else if (button[1]) digit = 2'd1;
        else if (button[2]) digit = 2'd2;
        cnt_inc    = digit_cnt_q + DCW'(1);
        fail_inc   = (fail_cnt_q == FCW'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + FCW'(1);
        timer_zero = (timer_q == '0);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        entry_d     = entry_q;
        timer_d     = timer_q;
        collision_d = |(button & (button - 4'd1));

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (btn_valid) begin
                    // digit_cnt is 0 in IDLE, so the same increment serves both states
                    entry_d     = EW'({entry_q, digit});
                    digit_cnt_d = cnt_inc;
                    timer_d     = TW'(TIMEOUT_CYCLES - 1);
                    state_d     = (cnt_inc == DCW'(CODE_LEN)) ? S_CHECK : S_ENTRY;
                end else if (state_q == S_ENTRY) begin
                    if (timer_zero) begin
                        // idle timeout abandons the attempt without counting a failure
                        state_d     = S_IDLE;
                        digit_cnt_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            S_CHECK: begin
                digit_cnt_d = '0;
                if (entry_q == SECRET) begin
                    state_d    = S_OPEN;
                    fail_cnt_d = '0;
                    timer_d    = TW'(OPEN_CYCLES - 1);
                end else begin
                    fail_cnt_d = fail_inc;
`ifdef LOCK_LOCKOUT_EN
                    if (fail_inc == FCW'(MAX_FAILS)) begin
                        state_d = S_LOCKOUT;
                        timer_d = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_OPEN: begin
                if (timer_zero) state_d = S_IDLE;
                else            timer_d = timer_q - TW'(1);
            end
`ifdef LOCK_LOCKOUT_EN
            S_LOCKOUT: begin
                if (timer_zero) begin
                    state_d    = S_IDLE;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        unlocked_d = (state_d == S_OPEN);
    end

    // State, counters, entry shift register and timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            digit_cnt_q <= '0;
            fail_cnt_q  <= '0;
            entry_q     <= '0;
            timer_q     <= '0;
            unlocked_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            entry_q     <= entry_d;
            timer_q     <= timer_d;
            unlocked_q  <= unlocked_d;
            collision_q <= collision_d;
        end
    end

`ifdef LOCK_LOCKOUT_EN
    logic locked_out_q;

    // Lockout indicator tracks the LOCKOUT state one-for-one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) locked_out_q <= 1'b0;
        else        locked_out_q <= (state_d == S_LOCKOUT);
    end

    assign locked_out = locked_out_q;
`else
    assign locked_out = 1'b0;
`endif

    assign state     = state_q;
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign unlocked  = unlocked_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: scoreboard of expected output vectors pushed as
// stimulus is driven and compared after each sampled edge.
// Observation vector layout: {state[2:0], digit_cnt[2:0], fail_cnt[1:0], unlocked, locked_out, collision}.
module tb_lock_sequencer;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned OPENC   = 8;
    localparam int unsigned LOCKC   = 32;
    localparam int unsigned MAXF    = 3;
    localparam logic [7:0]  SECRET_TB = 8'b00_01_10_11;

    localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2, S_OPEN = 3'd3, S_LOCK = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button;
    logic       unlocked, locked_out, collision;
    logic [2:0] state;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    lock_sequencer #(
        .CODE_LEN       (4),
        .SECRET         (SECRET_TB),
        .TIMEOUT_CYCLES (TIMEOUT),
        .OPEN_CYCLES    (OPENC),
        .LOCKOUT_CYCLES (LOCKC),
        .MAX_FAILS      (MAXF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .collision  (collision),
        .state      (state),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    wire [10:0] obs = {state, digit_cnt, fail_cnt, unlocked, locked_out, collision};

    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    int errors = 0;
    int checks = 0;
    int exp_fc = 0;

    function automatic logic [10:0] ev(input logic [2:0] st, input int dc, input int fc,
                                       input logic u, input logic l, input logic c);
        return {st, 3'(dc), 2'(fc), u, l, c};
    endfunction

    // One clock cycle with button=b; expected vector queued, observation captured.
    task automatic drive(input logic [3:0] b, input logic [10:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        button = b;
        @(posedge clk);
        #1;
        obs_q.push_back(obs);
        button = 4'd0;
    endtask

    // Enter a 4-digit code on consecutive cycles and queue the CHECK outcome.
    task automatic press_code(input logic [7:0] code);
        logic [1:0] d;
        int nf;
        for (int i = 0; i < 4; i++) begin
            d = code[7-2*i -: 2];
            drive(4'(1) << d, ev((i == 3) ? S_CHECK : S_ENTRY, i + 1, exp_fc, 1'b0, 1'b0, 1'b0));
        end
        if (code == SECRET_TB) begin
            exp_fc = 0;
            drive(4'd0, ev(S_OPEN, 0, 0, 1'b1, 1'b0, 1'b0));
        end else begin
            nf = (exp_fc < int'(MAXF)) ? exp_fc + 1 : int'(MAXF);
            exp_fc = nf;
`ifdef LOCK_LOCKOUT_EN
            if (nf == int'(MAXF)) drive(4'd0, ev(S_LOCK, 0, nf, 1'b0, 1'b1, 1'b0));
            else                  drive(4'd0, ev(S_IDLE, 0, nf, 1'b0, 1'b0, 1'b0));
`else
            drive(4'd0, ev(S_IDLE, 0, nf, 1'b0, 1'b0, 1'b0));
`endif
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        button = 4'd0;
        #12;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset: got %b want %b", obs, 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_correct_code;
        logic [10:0] e, g;
        logic [1:0]  d;
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            d = SECRET_TB[7-2*i -: 2];
            drive(4'(1) << d, ev((i == 3) ? S_CHECK : S_ENTRY, i + 1, exp_fc, 1'b0, 1'b0, 1'b0));
            if (i < 3) begin
                drive(4'd0, ev(S_ENTRY, i + 1, exp_fc, 1'b0, 1'b0, 1'b0));
                drive(4'd0, ev(S_ENTRY, i + 1, exp_fc, 1'b0, 1'b0, 1'b0));
            end
        end
        exp_fc = 0;
        // buttons in OPEN only register as a collision
        for (int k = 0; k < int'(OPENC); k++)
            drive((k == 3) ? 4'b1100 : 4'd0, ev(S_OPEN, 0, 0, 1'b1, 1'b0, k == 3));
        drive(4'd0, ev(S_IDLE, 0, 0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL correct_code[%0d]: got {st,dc,fc,u,l,c}=%0d,%0d,%0d,%b,%b,%b want %0d,%0d,%0d,%b,%b,%b",
                         n, g[10:8], g[7:5], g[4:3], g[2], g[1], g[0], e[10:8], e[7:5], e[4:3], e[2], e[1], e[0]);
            end
            n++;
        end
    endtask

    task automatic test_collision;
        logic [10:0] e, g;
        int n = 0;
        drive(4'b0110, ev(S_ENTRY, 1, exp_fc, 1'b0, 1'b0, 1'b1));
        for (int j = 1; j < int'(TIMEOUT); j++)
            drive(4'd0, ev(S_ENTRY, 1, exp_fc, 1'b0, 1'b0, 1'b0));
        drive(4'd0, ev(S_IDLE, 0, exp_fc, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL collision[%0d]: got {st,dc,fc,u,l,c}=%0d,%0d,%0d,%b,%b,%b want %0d,%0d,%0d,%b,%b,%b",
                         n, g[10:8], g[7:5], g[4:3], g[2], g[1], g[0], e[10:8], e[7:5], e[4:3], e[2], e[1], e[0]);
            end
            n++;
        end
    endtask

    task automatic test_timeout;
        logic [10:0] e, g;
        int n = 0;
        press_code(8'hFF);
        // abandoned attempt keeps the failure count
        drive(4'b0001, ev(S_ENTRY, 1, exp_fc, 1'b0, 1'b0, 1'b0));
        drive(4'b0010, ev(S_ENTRY, 2, exp_fc, 1'b0, 1'b0, 1'b0));
        for (int j = 1; j < int'(TIMEOUT); j++)
            drive(4'd0, ev(S_ENTRY, 2, exp_fc, 1'b0, 1'b0, 1'b0));
        drive(4'd0, ev(S_IDLE, 0, exp_fc, 1'b0, 1'b0, 1'b0));
        // a digit landing on the timer's last cycle is accepted
        drive(4'b0001, ev(S_ENTRY, 1, exp_fc, 1'b0, 1'b0, 1'b0));
        drive(4'b0010, ev(S_ENTRY, 2, exp_fc, 1'b0, 1'b0, 1'b0));
        for (int j = 1; j < int'(TIMEOUT); j++)
            drive(4'd0, ev(S_ENTRY, 2, exp_fc, 1'b0, 1'b0, 1'b0));
        drive(4'b0100, ev(S_ENTRY, 3, exp_fc, 1'b0, 1'b0, 1'b0));
        drive(4'b1000, ev(S_CHECK, 4, exp_fc, 1'b0, 1'b0, 1'b0));
        exp_fc = 0;
        for (int k = 0; k < int'(OPENC); k++)
            drive(4'd0, ev(S_OPEN, 0, 0, 1'b1, 1'b0, 1'b0));
        drive(4'd0, ev(S_IDLE, 0, 0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got {st,dc,fc,u,l,c}=%0d,%0d,%0d,%b,%b,%b want %0d,%0d,%0d,%b,%b,%b",
                         n, g[10:8], g[7:5], g[4:3], g[2], g[1], g[0], e[10:8], e[7:5], e[4:3], e[2], e[1], e[0]);
            end
            n++;
        end
    endtask

    task automatic test_lockout;
        logic [10:0] e, g;
        logic [3:0]  b;
        int n = 0;
        for (int a = 0; a < int'(MAXF); a++) press_code(8'hFF);
`ifdef LOCK_LOCKOUT_EN
        for (int k = 1; k < int'(LOCKC); k++) begin
            b = (k == 5 || k == 31) ? 4'b0001 : (k == 9) ? 4'b0011 : 4'd0;
            drive(b, ev(S_LOCK, 0, MAXF, 1'b0, 1'b1, k == 9));
        end
        exp_fc = 0;
        drive(4'b0001, ev(S_IDLE, 0, 0, 1'b0, 1'b0, 1'b0));
`else
        press_code(8'hFF);
        press_code(SECRET_TB);
        for (int k = 1; k < int'(OPENC); k++)
            drive(4'd0, ev(S_OPEN, 0, 0, 1'b1, 1'b0, 1'b0));
        drive(4'd0, ev(S_IDLE, 0, 0, 1'b0, 1'b0, 1'b0));
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL lockout[%0d]: got {st,dc,fc,u,l,c}=%0d,%0d,%0d,%b,%b,%b want %0d,%0d,%0d,%b,%b,%b",
                         n, g[10:8], g[7:5], g[4:3], g[2], g[1], g[0], e[10:8], e[7:5], e[4:3], e[2], e[1], e[0]);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] e, g;
        int n = 0;
        press_code(SECRET_TB);
        drive(4'd0, ev(S_OPEN, 0, 0, 1'b1, 1'b0, 1'b0));
        drive(4'd0, ev(S_OPEN, 0, 0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_in_open: got %b want %b", obs, 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_fc = 0;
        drive(4'd0, ev(S_IDLE, 0, 0, 1'b0, 1'b0, 1'b0));
        press_code(8'hFF);
        drive(4'b0001, ev(S_ENTRY, 1, exp_fc, 1'b0, 1'b0, 1'b0));
        drive(4'b0010, ev(S_ENTRY, 2, exp_fc, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_in_entry: got %b want %b", obs, 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_fc = 0;
        press_code(SECRET_TB);
        for (int k = 1; k < int'(OPENC); k++)
            drive(4'd0, ev(S_OPEN, 0, 0, 1'b1, 1'b0, 1'b0));
        drive(4'd0, ev(S_IDLE, 0, 0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = obs_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got {st,dc,fc,u,l,c}=%0d,%0d,%0d,%b,%b,%b want %0d,%0d,%0d,%b,%b,%b",
                         n, g[10:8], g[7:5], g[4:3], g[2], g[1], g[0], e[10:8], e[7:5], e[4:3], e[2], e[1], e[0]);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_collision();
        test_timeout();
        test_lockout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Run-length guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Attempt controller for the digital lock. It takes the four one-cycle button pulses from the edge detectors and arbitrates simultaneous presses. It then assembles them into a CODE_LEN-digit entry, compares the entry against a fixed secret, and sequences the unlock, failed-attempt and lockout phases. Its status outputs feed the seven-segment controller and LEDs in place of a free-running lock core.

## Interface
Parameters:
- CODE_LEN, 4: digits per attempt (≥1).
- SECRET, 8'b00_01_10_11: 2*CODE_LEN bits; first digit in the MS pair; digit = button index.
- TIMEOUT_CYCLES, 50_000_000: inter-digit idle limit (≥2).
- OPEN_CYCLES, 30_000_000: unlock hold time (≥1).
- LOCKOUT_CYCLES, 100_000_000: lockout duration (≥1).
- MAX_FAILS, 3: consecutive mismatches that trigger lockout (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- button  in  4  one-cycle press pulses, bit i = digit i.
- unlocked  out  1  high while in OPEN.
- locked_out  out  1  high while in LOCKOUT.
- collision  out  1  one-cycle pulse when more than one button bit is high in a cycle.
- state  out  3  IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits accepted in the current attempt.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive mismatches.

## Operation
- All outputs are registered. Reset value of every output is 0; state resets to IDLE and the entry register and timer reset to 0.
- Arbitration: in IDLE or ENTRY, the lowest set bit of `button` is accepted as the digit, and the others are dropped. `collision` pulses whenever popcount(button) > 1 in any state.
- Each accepted digit shifts into the entry register (shift left 2), increments digit_cnt, and reloads the timer to TIMEOUT_CYCLES-1.
- State transitions:
  - IDLE: on an accepted digit, go to ENTRY, or go directly to CHECK when CODE_LEN=1.
  - ENTRY: on an accepted digit that makes digit_cnt reach CODE_LEN, go to CHECK. Otherwise the timer decrements each cycle. When timer==0 and no pulse arrives, go to IDLE, clear digit_cnt, and leave fail_cnt unchanged; a timeout is not a failure.
  - CHECK: lasts one cycle and ignores buttons. On a match, go to OPEN, clear fail_cnt, and load the timer with OPEN_CYCLES-1. On a mismatch, fail_cnt+1; if the new value equals MAX_FAILS, go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1, else go to IDLE. digit_cnt clears on leaving CHECK.
  - OPEN: buttons are ignored apart from collision detection. Decrement the timer; at 0, go to IDLE.
  - LOCKOUT: buttons are ignored. Decrement the timer; at 0, go to IDLE and clear fail_cnt.
- fail_cnt never exceeds MAX_FAILS.

## Timing
- A pulse sampled at edge E moves the state and digit_cnt after E.
- When the last digit is sampled at edge E, state is CHECK for the cycle after E, and unlocked or locked_out rises after edge E+1.
- unlocked is high for exactly OPEN_CYCLES cycles; locked_out is high for exactly LOCKOUT_CYCLES cycles.
- Timeout: IDLE is entered TIMEOUT_CYCLES cycles after the edge that accepted the last digit.
- A pulse that arrives in the same cycle as the timer reaches 0 in ENTRY is accepted, and no timeout occurs.
- Reset asserted mid-attempt, mid-OPEN or mid-LOCKOUT immediately forces IDLE, clears all counters, and drives every output to 0.

## Configuration
- LOCK_LOCKOUT_EN defined: full behaviour as above.
- LOCK_LOCKOUT_EN undefined:
  - The LOCKOUT state and its timer are not built.
  - A mismatch always goes to IDLE.
  - fail_cnt still counts and saturates at MAX_FAILS, and clears on a match.
  - locked_out is tied to 0.
  - LOCKOUT_CYCLES is unused.

## Test plan
Bench overrides: TIMEOUT_CYCLES=16, OPEN_CYCLES=8, LOCKOUT_CYCLES=32, MAX_FAILS=3, SECRET=8'b00_01_10_11.

- **Correct code:** pulses on buttons 0, 1, 2, 3, spaced 3 cycles apart. Required: state passes through CHECK for 1 cycle, unlocked is high for exactly 8 cycles, then state returns to IDLE and fail_cnt=0.
- **Collision:** button=4'b0110 in IDLE. Required: collision pulses for 1 cycle, digit 1 is accepted, digit_cnt=1.
- **Timeout:** digits 0, 1, then no input for 16 cycles. Required: state returns to IDLE, digit_cnt=0, fail_cnt unchanged. A third digit arriving on cycle 16 must instead be accepted.
- **Lockout:** three wrong codes (3,3,3,3). Required: fail_cnt goes 1, 2, then locked_out is high for 32 cycles with buttons ignored, then IDLE with fail_cnt=0. Without LOCK_LOCKOUT_EN: fail_cnt=3 and locked_out stays 0.
- **Reset mid-operation:** rst_n asserted low for 1 cycle during OPEN and again during ENTRY with digit_cnt=2. Required: all outputs are 0 immediately, and a following correct code unlocks normally.
